ps_bigreg_collector: RTL and testbench
======================================

// Module: ps_bigreg_collector
// PURPOSE
// Sequences collection of one PS_BIGREG group (seed, chan_mux or sdc) from the AXI mem_map.
// Waits for the group's VALID_ID fresh bit, then reads BASE_ID..BASE_ID+SAMPLES-1 over the mem_map read port.
// Assembles the words into one wide register, clears the consumed fresh bits and presents the result to the RTL consumer.
// Uses a valid/ready handshake. One instance per group sits between the AXI slave mem_map and the consumer.
// PARAMETERS
// MEM_SIZE  256  mem_map depth; ID_W = $clog2(MEM_SIZE)
// DATA_W    16   bits per mem_map entry (WD_DATA_WIDTH)
// BASE_ID   1    first data index of the group; VALID_ID = BASE_ID+SAMPLES
// SAMPLES   16   data entries in the group; legal range >= 1 (seed 16, chan_mux 2, sdc 16)
// PORTS
// clk           in   1                 system clock
// rst_n         in   1                 async active-low reset
// flush_i       in   1                 sync abort, pulsed when the RST_ID poll fires
// fresh_i       in   SAMPLES+1         fresh bits of BASE_ID..VALID_ID; [SAMPLES] = valid entry
// clr_fresh_o   out  SAMPLES+1         one-cycle clear strobe for the fresh bits
// mem_rd_en_o   out  1                 mem_map read request
// mem_rd_id_o   out  ID_W              mem_map read index
// mem_rd_data_i in   DATA_W            read data, valid exactly 1 cycle after mem_rd_en_o
// reg_o         out  SAMPLES*DATA_W    assembled register; word k at [k*DATA_W +: DATA_W]
// reg_valid_o   out  1                 reg_o holds a complete transaction
// reg_ready_i   in   1                 consumer accepts reg_o
// busy_o        out  1                 state != IDLE
// BEHAVIOUR
// Reset: every output is 0; state = IDLE; snapshot mask and index = 0. reg_o is cleared to 0.
// State IDLE:
//   - If fresh_i[SAMPLES]=1, snapshot mask <= fresh_i, rd_idx <= 0, next state READ.
//   - Otherwise remain in IDLE.
// State READ:
//   - mem_rd_en_o=1 and mem_rd_id_o=BASE_ID+rd_idx, one read per cycle; rd_idx increments.
//   - When rd_idx==SAMPLES-1, next state DRAIN.
// Capture:
//   - A registered copy of en/idx writes mem_rd_data_i into word idx one cycle after each read.
//   - Every word is read, including words whose fresh bit is clear; their prior PS value is reused.
// State DRAIN: captures the last word; next state CLEAR.
// State CLEAR: clr_fresh_o = snapshot mask for exactly 1 cycle; next state PRESENT.
// State PRESENT:
//   - reg_valid_o=1.
//   - On reg_ready_i=1, the handshake completes in that same cycle and the next state is IDLE.
// Timing:
//   - Latency: valid fresh bit seen in IDLE at cycle t gives reg_valid_o=1 at t+SAMPLES+3.
//   - Minimum period between transactions is SAMPLES+4 cycles.
// reg_o hold rule:
//   - reg_o is stable while reg_valid_o=1.
//   - It is only written during READ/DRAIN capture.
// Simultaneous events:
//   - A new valid fresh bit during any non-IDLE state is left untouched; it is serviced from IDLE after the handshake.
//   - Bits set after the snapshot are not cleared by CLEAR.
//   - An entry rewritten by the PS during collection may or may not be captured. It is not cleared if absent from the snapshot.
// flush_i:
//   - Highest priority in every state.
//   - Next state IDLE, reg_valid_o drops next cycle, no clr_fresh_o pulse, pending capture discarded.
//   - A flush that coincides with the handshake is still a completed handshake.
// Async reset mid-operation:
//   - Returns to IDLE immediately and fresh bits stay set.
//   - The group is re-collected after reset release if still fresh.
// SAMPLES=1: READ lasts one cycle and then DRAIN.
// Widths:
//   - BASE_ID+rd_idx is computed in ID_W bits.
//   - An elaboration assertion requires BASE_ID+SAMPLES < MEM_SIZE.
// STRUCTURE
// Shared mem layout package holds:
//   - the collector_state_t enum (IDLE, READ, DRAIN, CLEAR, PRESENT);
//   - per-group BASE_ID/SAMPLES localparams (PS_SEED, CHAN_MUX, SDC).
// Single module with no sub-module: the FSM, index counter, capture pipe register and assembly register are all local.
// TESTING
// T1 (SAMPLES=16, BASE=1): fresh 0x1FFFF with mem[1+k]=0x1000+k.
//   Expect reg_valid_o at t+19, word k=0x1000+k, clr_fresh_o=0x1FFFF for 1 cycle, mem_rd_id 1..16 consecutive.
// T2 backpressure: hold reg_ready_i=0 for 10 cycles and set valid fresh again during PRESENT.
//   Expect reg_o stable, no reads during hold, second READ starting 1 cycle after ready.
// T3 (SAMPLES=2, BASE=30): fresh_i=3'b101.
//   Expect both words read and clr_fresh_o=3'b101; a bit set mid-READ is not cleared.
// T4: flush_i at the 3rd READ cycle.
//   Expect IDLE next cycle, no clr pulse, reg_valid_o=0, re-collection when valid is still fresh.
// T5: rst_n low during DRAIN.
//   Expect all outputs 0 asynchronously and a full recollection after release; check SAMPLES=1 latency = 4.

Source files
------------

// File: rtl/ps_bigreg_collector_pkg.sv
// Shared mem_map layout for the PS_BIGREG groups and the collector state encoding.
package ps_bigreg_collector_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    DRAIN,
    CLEAR,
    PRESENT
  } collector_state_t;

  localparam int MEM_MAP_SIZE  = 256;
  localparam int WD_DATA_WIDTH = 16;

  localparam int PS_SEED_BASE_ID  = 1;
  localparam int PS_SEED_SAMPLES  = 16;
  localparam int CHAN_MUX_BASE_ID = 30;
  localparam int CHAN_MUX_SAMPLES = 2;
  localparam int SDC_BASE_ID      = 40;
  localparam int SDC_SAMPLES      = 16;

  // The group's fresh/valid flag lives directly after its data entries.
  function automatic int valid_id(input int base_id, input int samples);
    return base_id + samples;
  endfunction

endpackage

// File: rtl/ps_bigreg_collector_if.sv
// mem_map read port plus the assembled-register valid/ready channel of one collector.
interface ps_bigreg_collector_if
  import ps_bigreg_collector_pkg::*;
#(
  parameter int ID_W    = $clog2(MEM_MAP_SIZE),
  parameter int DATA_W  = WD_DATA_WIDTH,
  parameter int SAMPLES = PS_SEED_SAMPLES
);

  logic                      mem_rd_en;
  logic [ID_W-1:0]           mem_rd_id;
  logic [DATA_W-1:0]         mem_rd_data;
  logic [SAMPLES*DATA_W-1:0] reg_data;
  logic                      reg_valid;
  logic                      reg_ready;

  modport master (
    output mem_rd_en, mem_rd_id, reg_data, reg_valid,
    input  mem_rd_data, reg_ready
  );

  modport slave (
    input  mem_rd_en, mem_rd_id, reg_data, reg_valid,
    output mem_rd_data, reg_ready
  );

endinterface

// File: rtl/ps_bigreg_collector.sv
// Collects one PS_BIGREG group from mem_map into a wide register once its valid bit is fresh.
// Latency SAMPLES+3 from fresh valid to reg_valid; holds reg_data stable until reg_ready.
module ps_bigreg_collector
  import ps_bigreg_collector_pkg::*;
#(
  parameter int MEM_SIZE = MEM_MAP_SIZE,
  parameter int DATA_W   = WD_DATA_WIDTH,
  parameter int BASE_ID  = PS_SEED_BASE_ID,
  parameter int SAMPLES  = PS_SEED_SAMPLES
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush_i,
  input  logic [SAMPLES:0]   fresh_i,
  output logic [SAMPLES:0]   clr_fresh_o,
  output logic               busy_o,
  ps_bigreg_collector_if.master bus
);

  localparam int ID_W     = $clog2(MEM_SIZE);
  localparam int IDX_W    = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;
  localparam int VALID_ID = valid_id(BASE_ID, SAMPLES);

  if (SAMPLES < 1) begin : g_bad_samples
    $error("ps_bigreg_collector: SAMPLES must be at least 1");
  end
  if (VALID_ID >= MEM_SIZE) begin : g_bad_range
    $error("ps_bigreg_collector: BASE_ID+SAMPLES must be below MEM_SIZE");
  end

  collector_state_t          r_state;
  collector_state_t          w_next_state;
  logic [SAMPLES:0]          r_mask;
  logic [IDX_W-1:0]          r_rd_idx;
  logic                      r_cap_en;
  logic [IDX_W-1:0]          r_cap_idx;
  logic [SAMPLES*DATA_W-1:0] r_reg;
  logic                      w_start;

  assign w_start = (r_state == IDLE) && fresh_i[SAMPLES] && !flush_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (fresh_i[SAMPLES]) w_next_state = READ;
      READ:    if (r_rd_idx == IDX_W'(SAMPLES - 1)) w_next_state = DRAIN;
      DRAIN:   w_next_state = CLEAR;
      CLEAR:   w_next_state = PRESENT;
      PRESENT: if (bus.reg_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
    if (flush_i) w_next_state = IDLE;
  end

  assign bus.mem_rd_en = (r_state == READ);
  assign bus.mem_rd_id = (r_state == READ) ? ID_W'(BASE_ID) + ID_W'(r_rd_idx) : '0;
  assign bus.reg_valid = (r_state == PRESENT);
  assign bus.reg_data  = r_reg;
  assign busy_o        = (r_state != IDLE);
  // Only the bits seen at snapshot time are cleared; later arrivals stay pending.
  assign clr_fresh_o   = ((r_state == CLEAR) && !flush_i) ? r_mask : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mask   <= '0;
      r_rd_idx <= '0;
    end else if (w_start) begin
      r_mask   <= fresh_i;
      r_rd_idx <= '0;
    end else if (r_state == READ) begin
      r_rd_idx <= r_rd_idx + IDX_W'(1);
    end
  end

  // Read data arrives one cycle after the request, so en/idx are delayed to match.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cap_en  <= 1'b0;
      r_cap_idx <= '0;
      r_reg     <= '0;
    end else begin
      r_cap_en  <= bus.mem_rd_en && !flush_i;
      r_cap_idx <= r_rd_idx;
      if (r_cap_en && !flush_i) begin
        r_reg[r_cap_idx*DATA_W +: DATA_W] <= bus.mem_rd_data;
      end
    end
  end

endmodule

// File: tb/tb_ps_bigreg_collector.sv
// Three collectors (16-word, 2-word, 1-word groups) driven against a mem_map and fresh-bit model.
module tb_ps_bigreg_collector;
  import ps_bigreg_collector_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        rdy = 1'b0;
  logic [1:0]  sel = 2'd0;
  logic [16:0] set_bits = '0;
  logic [15:0] mem [0:255];
  int          checks = 0;
  int          errors = 0;

  logic [16:0] fresh_a = '0;
  logic [2:0]  fresh_b = '0;
  logic [1:0]  fresh_c = '0;
  logic [16:0] clr_a;
  logic [2:0]  clr_b;
  logic [1:0]  clr_c;
  logic        busy_a, busy_b, busy_c;

  logic        obs_rd_en, obs_valid, obs_busy;
  logic [7:0]  obs_rd_id;
  logic [16:0] obs_clr, obs_fresh;
  logic [255:0] obs_reg;
  logic [255:0] exp_reg;

  always #5 clk = ~clk;

  ps_bigreg_collector_if #(.ID_W(8), .DATA_W(16), .SAMPLES(PS_SEED_SAMPLES))  if_a ();
  ps_bigreg_collector_if #(.ID_W(8), .DATA_W(16), .SAMPLES(CHAN_MUX_SAMPLES)) if_b ();
  ps_bigreg_collector_if #(.ID_W(8), .DATA_W(16), .SAMPLES(1))                if_c ();

  assign if_a.reg_ready = rdy;
  assign if_b.reg_ready = rdy;
  assign if_c.reg_ready = rdy;

  ps_bigreg_collector #(.MEM_SIZE(256), .DATA_W(16), .BASE_ID(PS_SEED_BASE_ID), .SAMPLES(PS_SEED_SAMPLES)) u_a (
    .clk(clk), .rst_n(rst_n), .flush_i(flush), .fresh_i(fresh_a),
    .clr_fresh_o(clr_a), .busy_o(busy_a), .bus(if_a));
  ps_bigreg_collector #(.MEM_SIZE(256), .DATA_W(16), .BASE_ID(CHAN_MUX_BASE_ID), .SAMPLES(CHAN_MUX_SAMPLES)) u_b (
    .clk(clk), .rst_n(rst_n), .flush_i(flush), .fresh_i(fresh_b),
    .clr_fresh_o(clr_b), .busy_o(busy_b), .bus(if_b));
  ps_bigreg_collector #(.MEM_SIZE(256), .DATA_W(16), .BASE_ID(5), .SAMPLES(1)) u_c (
    .clk(clk), .rst_n(rst_n), .flush_i(flush), .fresh_i(fresh_c),
    .clr_fresh_o(clr_c), .busy_o(busy_c), .bus(if_c));

  // Fresh bits are PS-owned: set by the bench, cleared only by strobes, untouched by reset.
  always @(posedge clk) begin
    fresh_a <= (fresh_a & ~clr_a) | ((sel == 2'd0) ? set_bits : 17'h0);
    fresh_b <= (fresh_b & ~clr_b) | ((sel == 2'd1) ? set_bits[2:0] : 3'h0);
    fresh_c <= (fresh_c & ~clr_c) | ((sel == 2'd2) ? set_bits[1:0] : 2'h0);
    if (if_a.mem_rd_en) if_a.mem_rd_data <= mem[if_a.mem_rd_id];
    if (if_b.mem_rd_en) if_b.mem_rd_data <= mem[if_b.mem_rd_id];
    if (if_c.mem_rd_en) if_c.mem_rd_data <= mem[if_c.mem_rd_id];
  end

  always_comb begin
    obs_rd_en = 1'b0; obs_rd_id = '0; obs_clr = '0; obs_valid = 1'b0;
    obs_busy = 1'b0; obs_reg = '0; obs_fresh = '0;
    case (sel)
      2'd0: begin
        obs_rd_en = if_a.mem_rd_en; obs_rd_id = if_a.mem_rd_id; obs_clr = clr_a;
        obs_valid = if_a.reg_valid; obs_busy = busy_a; obs_reg = if_a.reg_data;
        obs_fresh = fresh_a;
      end
      2'd1: begin
        obs_rd_en = if_b.mem_rd_en; obs_rd_id = if_b.mem_rd_id; obs_clr = {14'b0, clr_b};
        obs_valid = if_b.reg_valid; obs_busy = busy_b; obs_reg = {224'b0, if_b.reg_data};
        obs_fresh = {14'b0, fresh_b};
      end
      default: begin
        obs_rd_en = if_c.mem_rd_en; obs_rd_id = if_c.mem_rd_id; obs_clr = {15'b0, clr_c};
        obs_valid = if_c.reg_valid; obs_busy = busy_c; obs_reg = {240'b0, if_c.reg_data};
        obs_fresh = {15'b0, fresh_c};
      end
    endcase
  end

  function automatic int s_of(input logic [1:0] s);
    return (s == 2'd0) ? PS_SEED_SAMPLES : (s == 2'd1) ? CHAN_MUX_SAMPLES : 1;
  endfunction

  function automatic int b_of(input logic [1:0] s);
    return (s == 2'd0) ? PS_SEED_BASE_ID : (s == 2'd1) ? CHAN_MUX_BASE_ID : 5;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic start(input logic [16:0] set);
    set_bits = set;
    tick();
    set_bits = '0;
  endtask

  // Called in the IDLE cycle where the valid fresh bit is visible; walks the whole collection.
  task automatic check_collect(input logic [16:0] mid_set);
    int s, b;
    logic [16:0] snap;
    s = s_of(sel);
    b = b_of(sel);
    snap = obs_fresh;
    exp_reg = '0;
    for (int k = 0; k < s; k++) exp_reg[k*16 +: 16] = mem[b+k];
    checks++;
    if (obs_busy !== 1'b0 || snap[s] !== 1'b1) begin
      errors++;
      $display("FAIL start_idle busy=%b fresh_valid=%b want busy=0 fresh_valid=1", obs_busy, snap[s]);
    end
    for (int j = 1; j <= s + 3; j++) begin
      tick();
      set_bits = (j == 1) ? mid_set : '0;
      checks++;
      if (j <= s) begin
        if (obs_rd_en !== 1'b1 || obs_rd_id !== 8'(b + j - 1) || obs_valid !== 1'b0) begin
          errors++;
          $display("FAIL read cyc=%0d en=%b id=%0d valid=%b want en=1 id=%0d valid=0",
                   j, obs_rd_en, obs_rd_id, obs_valid, b + j - 1);
        end
      end else if (j == s + 1) begin
        if (obs_rd_en !== 1'b0 || obs_clr !== 17'h0 || obs_valid !== 1'b0) begin
          errors++;
          $display("FAIL drain en=%b clr=%h valid=%b want 0/0/0", obs_rd_en, obs_clr, obs_valid);
        end
      end else if (j == s + 2) begin
        if (obs_clr !== snap || obs_valid !== 1'b0) begin
          errors++;
          $display("FAIL clear clr=%h valid=%b want clr=%h valid=0", obs_clr, obs_valid, snap);
        end
      end else begin
        if (obs_valid !== 1'b1 || obs_clr !== 17'h0) begin
          errors++;
          $display("FAIL present valid=%b clr=%h want valid=1 clr=0", obs_valid, obs_clr);
        end
        checks++;
        if (obs_reg !== exp_reg) begin
          errors++;
          $display("FAIL reg got %h want %h", obs_reg, exp_reg);
        end
      end
    end
    set_bits = '0;
  endtask

  task automatic hold(input int n, input int set_at);
    for (int i = 0; i < n; i++) begin
      checks++;
      if (obs_valid !== 1'b1 || obs_rd_en !== 1'b0 || obs_reg !== exp_reg) begin
        errors++;
        $display("FAIL hold cyc=%0d valid=%b en=%b reg=%h want valid=1 en=0 reg=%h",
                 i, obs_valid, obs_rd_en, obs_reg, exp_reg);
      end
      set_bits = (i == set_at) ? 17'h1FFFF : 17'h0;
      tick();
    end
    set_bits = '0;
  endtask

  task automatic handshake();
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
    checks++;
    if (obs_valid !== 1'b0 || obs_busy !== 1'b0) begin
      errors++;
      $display("FAIL hs_drop valid=%b busy=%b want 0/0", obs_valid, obs_busy);
    end
  endtask

  task automatic check_fresh(input logic [16:0] want);
    checks++;
    if (obs_fresh !== want) begin
      errors++;
      $display("FAIL fresh got %h want %h", obs_fresh, want);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    checks++;
    if ({obs_busy, obs_rd_en, obs_valid, obs_clr, obs_rd_id} !== '0 || obs_reg !== '0) begin
      errors++;
      $display("FAIL %s busy=%b en=%b valid=%b clr=%h id=%0d reg=%h want all 0",
               tag, obs_busy, obs_rd_en, obs_valid, obs_clr, obs_rd_id, obs_reg);
    end
  endtask

  task automatic test_reset();
    tick();
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s);
      #1;
      check_outputs_zero("reset");
    end
    sel = 2'd0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_t1();
    sel = 2'd0;
    for (int k = 0; k < 16; k++) mem[1+k] = 16'h1000 + 16'(k);
    start(17'h1FFFF);
    check_collect(17'h0);
    handshake();
    check_fresh(17'h0);
  endtask

  task automatic test_t2_backpressure();
    sel = 2'd0;
    for (int k = 0; k < 16; k++) mem[1+k] = 16'($urandom);
    start(17'h1FFFF);
    check_collect(17'h0);
    hold(10, 2);
    handshake();
    check_collect(17'h0);
    handshake();
    check_fresh(17'h0);
  endtask

  task automatic test_t3_chan_mux();
    sel = 2'd1;
    mem[30] = 16'($urandom);
    mem[31] = 16'($urandom);
    start(17'h5);
    check_collect(17'h2);
    handshake();
    check_fresh(17'h2);
    repeat (3) tick();
    checks++;
    if (obs_busy !== 1'b0) begin
      errors++;
      $display("FAIL late_bit_idle busy=%b want 0", obs_busy);
    end
  endtask

  task automatic test_t4_flush();
    sel = 2'd0;
    for (int k = 0; k < 16; k++) mem[1+k] = 16'($urandom);
    start(17'h1FFFF);
    for (int j = 1; j <= 3; j++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (obs_busy !== 1'b0 || obs_valid !== 1'b0 || obs_clr !== 17'h0 || obs_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL flush busy=%b valid=%b clr=%h en=%b want all 0", obs_busy, obs_valid, obs_clr, obs_rd_en);
    end
    check_fresh(17'h1FFFF);
    check_collect(17'h0);
    handshake();
    check_fresh(17'h0);
  endtask

  task automatic test_t5_async_reset();
    sel = 2'd0;
    for (int k = 0; k < 16; k++) mem[1+k] = 16'($urandom);
    start(17'h1FFFF);
    for (int j = 1; j <= 17; j++) tick();
    rst_n = 1'b0;
    #1;
    check_outputs_zero("async_rst");
    tick();
    tick();
    rst_n = 1'b1;
    check_fresh(17'h1FFFF);
    check_collect(17'h0);
    handshake();
    sel = 2'd2;
    mem[5] = 16'($urandom);
    start(17'h3);
    check_collect(17'h0);
    handshake();
    check_fresh(17'h0);
  endtask

  task automatic test_random();
    int s, b;
    logic [16:0] set;
    for (int n = 0; n < 8; n++) begin
      sel = 2'($urandom_range(0, 2));
      s = s_of(sel);
      b = b_of(sel);
      for (int k = 0; k < s; k++) mem[b+k] = 16'($urandom);
      set = 17'($urandom);
      set[s] = 1'b1;
      start(set);
      check_collect(17'h0);
      hold($urandom_range(0, 3), -1);
      handshake();
      check_fresh(17'h0);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    test_reset();
    test_t1();
    test_t2_backpressure();
    test_t3_chan_mux();
    test_t4_flush();
    test_t5_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
